// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII character constants, framer state encoding and lane-mask helpers.
package xgmii_pkg;

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_ERR   = 8'hFE;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DISCARD
    } state_t;

    function automatic logic [7:0] keep_mask(input logic [2:0] n);
        return (8'd1 << n) - 8'd1;
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{keep[i]}};
        return m;
    endfunction

endpackage

// File: rtl/xgmii_lane_decode.sv
// xgmii_lane_decode: combinational classification of one aligned XGMII word.
module xgmii_lane_decode
    import xgmii_pkg::*;
(
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    output logic [2:0]  term_lane,
    output logic        has_term,
    output logic [2:0]  err_lane,
    output logic        has_err,
    output logic        err_is_start,
    output logic        has_start,
    output logic        ctl_any,
    output logic        start_ok
);

    // Descending scan so the lowest matching lane is the one left standing.
    always_comb begin
        term_lane    = '0;
        has_term     = 1'b0;
        err_lane     = '0;
        has_err      = 1'b0;
        err_is_start = 1'b0;
        has_start    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (rxc[i] && rxd[8*i +: 8] == CH_TERM) begin
                term_lane = 3'(i);
                has_term  = 1'b1;
            end else if (rxc[i]) begin
                err_lane     = 3'(i);
                has_err      = 1'b1;
                err_is_start = rxd[8*i +: 8] == CH_START;
            end
            if (rxc[i] && rxd[8*i +: 8] == CH_START) has_start = 1'b1;
        end
    end

    assign ctl_any  = |rxc;
    assign start_ok = rxc == 8'h01 && rxd[7:0] == CH_START &&
                      rxd[55:8] == {6{CH_PRE}} && rxd[63:56] == CH_SFD;

endmodule

// File: rtl/xgmii_rx_framer.sv
// xgmii_rx_framer: strips preamble/SFD and framing from an aligned XGMII stream and
// emits registered 64-bit beats with keep/last/err, plus good and bad frame counters.
module xgmii_rx_framer
    import xgmii_pkg::*;
#(
    parameter int MaxWords = 192
) (
    input  logic        xgmii_rx_clk,
    input  logic        sys_rst_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [63:0] rx_data,
    output logic [7:0]  rx_keep,
    output logic        rx_valid,
    output logic        rx_last,
    output logic        rx_err,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_cnt
);

    localparam logic [8:0] MAX_BEATS = 9'(MaxWords);

    state_t      state, data_next;
    logic [63:0] in_d, hold;
    logic [7:0]  in_c, hold_keep;
    logic        hold_v, hold_fin, hold_err;
    logic [8:0]  beat_cnt;
    logic [2:0]  term_lane, err_lane, part_lane;
    logic        has_term, has_err, err_is_start, has_start, ctl_any, start_ok;
    logic        in_data, term0, ctl_err, overflow, end_err, end_frame, emit;
    logic        accept, restart, load_part, empty_end, bad_pre, good_inc, err_inc;

    xgmii_lane_decode u_decode (
        .rxd          (in_d),
        .rxc          (in_c),
        .term_lane    (term_lane),
        .has_term     (has_term),
        .err_lane     (err_lane),
        .has_err      (has_err),
        .err_is_start (err_is_start),
        .has_start    (has_start),
        .ctl_any      (ctl_any),
        .start_ok     (start_ok)
    );

    // The registered input word is classified while hold carries the previous data word.
    always_comb begin
        in_data   = state == ST_DATA;
        term0     = has_term && term_lane == 3'd0;
        ctl_err   = has_err && (!has_term || err_lane < term_lane);
        overflow  = !ctl_err && !term0 && beat_cnt == MAX_BEATS;
        end_err   = ctl_err || overflow;
        end_frame = end_err || term0;
        emit      = in_data && hold_v;
        accept    = !ctl_any && !overflow;
        restart   = ctl_err && err_is_start && start_ok;
        load_part = in_data && !overflow &&
                    (ctl_err ? !hold_v && err_lane != 3'd0 : has_term && !term0);
        empty_end = in_data && !hold_v && (ctl_err ? err_lane == 3'd0 : term0);
        part_lane = ctl_err ? err_lane : term_lane;
        bad_pre   = state == ST_IDLE && in_c[0] && in_d[7:0] == CH_START && !start_ok;
        good_inc  = (emit && end_frame && !end_err) || (hold_fin && !hold_err);
        err_inc   = (emit && end_err) || (hold_fin && hold_err) || empty_end;
        data_next = (accept || restart) ? ST_DATA :
                    ((ctl_err && err_is_start) || has_term) ? ST_IDLE : ST_DISCARD;
    end

    always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            in_d      <= {8{CH_IDLE}};
            in_c      <= '1;
            hold      <= '0;
            hold_keep <= '0;
            hold_v    <= 1'b0;
            hold_fin  <= 1'b0;
            hold_err  <= 1'b0;
            beat_cnt  <= '0;
            rx_data   <= '0;
            rx_keep   <= '0;
            rx_valid  <= 1'b0;
            rx_last   <= 1'b0;
            rx_err    <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            in_d      <= xgmii_rxd;
            in_c      <= xgmii_rxc;
            rx_valid  <= emit || hold_fin;
            rx_data   <= (emit || hold_fin) ? hold : '0;
            rx_keep   <= hold_fin ? hold_keep : emit ? 8'hFF : 8'h00;
            rx_last   <= hold_fin || (emit && end_frame);
            rx_err    <= hold_fin ? hold_err : emit && end_err;
            frame_cnt <= frame_cnt + 32'(good_inc);
            err_cnt   <= err_cnt + 32'(err_inc) + 32'(bad_pre);
            // A pending partial beat always flushes on the following edge.
            hold_fin  <= load_part;
            hold_v    <= in_data && (accept || load_part);
            hold      <= (in_data && accept) ? in_d :
                         load_part ? in_d & byte_mask(keep_mask(part_lane)) : hold;
            hold_keep <= load_part ? keep_mask(part_lane) : hold_keep;
            hold_err  <= load_part ? ctl_err : hold_err;
            beat_cnt  <= (in_data && accept) ? beat_cnt + 9'd1 :
                         (state == ST_IDLE || restart) ? 9'd0 : beat_cnt;
            case (state)
                ST_IDLE:    state <= start_ok ? ST_DATA : ST_IDLE;
                ST_DATA:    state <= data_next;
                ST_DISCARD: state <= (has_term || has_start) ? ST_IDLE : ST_DISCARD;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_rx_framer.sv
// tb_xgmii_rx_framer: directed vectors for the XGMII receive framer with a beat
// monitor queue and hand-computed expected beats and counter values.
module tb_xgmii_rx_framer;

    localparam logic [63:0] START_W = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] BADPRE_W = 64'hD455_5555_5555_55FB;
    localparam logic [63:0] IDLE_W  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] TERM0_W = 64'h0707_0707_0707_07FD;
    localparam logic [63:0] TERM3_W = 64'h0707_0707_FD33_2211;
    localparam logic [63:0] TS_W    = 64'h0707_07FB_07FD_7766;
    localparam logic [63:0] FE0_W   = 64'h0000_0000_0000_00FE;
    localparam logic [63:0] A       = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B       = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C       = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] D       = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [63:0] E       = 64'h5A5A_A5A5_3C3C_C3C3;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic [63:0] rx_data;
    logic [7:0]  rx_keep;
    logic        rx_valid, rx_last, rx_err;
    logic [31:0] frame_cnt, err_cnt;
    beat_t       beats[$];
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    xgmii_rx_framer #(.MaxWords(192)) dut (
        .xgmii_rx_clk (clk),
        .sys_rst_n    (rst_n),
        .xgmii_rxd    (rxd),
        .xgmii_rxc    (rxc),
        .rx_data      (rx_data),
        .rx_keep      (rx_keep),
        .rx_valid     (rx_valid),
        .rx_last      (rx_last),
        .rx_err       (rx_err),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    always @(negedge clk) if (rx_valid) beats.push_back({rx_data, rx_keep, rx_last, rx_err});

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] c);
        rxd = d;
        rxc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(IDLE_W, 8'hFF);
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] d, input logic [7:0] k,
                               input logic l, input logic e);
        beat_t b;
        if (beats.size() == 0) begin
            total++;
            $display("FAIL %s: no beat observed, expected data %h", tag, d);
        end else begin
            b = beats.pop_front();
            check(tag, b.d, d);
            check({tag, "_flags"}, 64'({b.k, b.l, b.e}), 64'({k, l, e}));
        end
    endtask

    task automatic expect_none(input string tag);
        check(tag, 64'(beats.size()), 64'd0);
    endtask

    task automatic check_cnt(input string tag, input int f, input int e);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(f));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(e));
    endtask

    function automatic logic [63:0] ow(input int i);
        return {32'hC0DE_0000, 32'(i)};
    endfunction

    initial begin
        rxd = IDLE_W;
        rxc = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", rx_data, 64'd0);
        check("rst_flags", 64'({rx_keep, rx_valid, rx_last, rx_err}), 64'd0);
        check_cnt("rst", 0, 0);
        rst_n = 1'b1;
        idle(2);

        // Reset while the second beat of a five-word frame is on the outputs.
        send(START_W, 8'h01);
        send(64'h1111_0000_0000_0001, 8'h00);
        send(64'h1111_0000_0000_0002, 8'h00);
        send(64'h1111_0000_0000_0003, 8'h00);
        send(64'h1111_0000_0000_0004, 8'h00);
        check("mid_beat2", rx_data, 64'h1111_0000_0000_0002);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", rx_data, 64'd0);
        check("mid_rst_flags", 64'({rx_keep, rx_valid, rx_last, rx_err}), 64'd0);
        check_cnt("mid_rst", 0, 0);
        expect_beat("mid_beat1", 64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        expect_none("mid_none");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        send(64'h1111_0000_0000_0005, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_none("post_rst_quiet");
        check_cnt("post_rst", 0, 0);

        // Clean two-beat frame, with exact output latency checked.
        send(START_W, 8'h01);
        send(A, 8'h00);
        send(B, 8'h00);
        send(TERM0_W, 8'h01);
        check("lat_a_data", rx_data, A);
        check("lat_a_flags", 64'({rx_keep, rx_valid, rx_last, rx_err}), 64'({8'hFF, 3'b100}));
        send(IDLE_W, 8'hFF);
        check("lat_b_flags", 64'({rx_keep, rx_valid, rx_last, rx_err}), 64'({8'hFF, 3'b110}));
        check("lat_frame_cnt", 64'(frame_cnt), 64'd1);
        idle(3);
        expect_beat("f1_a", A, 8'hFF, 1'b0, 1'b0);
        expect_beat("f1_b", B, 8'hFF, 1'b1, 1'b0);
        expect_none("f1_none");
        check_cnt("f1", 1, 0);

        // Terminate on lane 3 leaves a three-byte tail beat.
        send(START_W, 8'h01);
        send(A, 8'h00);
        send(TERM3_W, 8'hF8);
        idle(4);
        expect_beat("t3_a", A, 8'hFF, 1'b0, 1'b0);
        expect_beat("t3_tail", 64'h0000_0000_0033_2211, 8'h07, 1'b1, 1'b0);
        expect_none("t3_none");
        check_cnt("t3", 2, 0);

        // Bad SFD is dropped and counted; the next frame is unaffected.
        send(BADPRE_W, 8'h01);
        idle(1);
        check_cnt("badpre", 2, 1);
        send(START_W, 8'h01);
        send(C, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_beat("badpre_c", C, 8'hFF, 1'b1, 1'b0);
        expect_none("badpre_none");
        check_cnt("badpre_next", 3, 1);

        // Error character ends the frame; data is discarded until terminate.
        send(START_W, 8'h01);
        send(A, 8'h00);
        send(FE0_W, 8'h01);
        send(D, 8'h00);
        send(D, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_beat("fe_a", A, 8'hFF, 1'b1, 1'b1);
        expect_none("fe_none");
        check_cnt("fe", 3, 2);
        send(START_W, 8'h01);
        send(E, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_beat("fe_next", E, 8'hFF, 1'b1, 1'b0);
        check_cnt("fe_next", 4, 2);

        // Empty frame.
        send(START_W, 8'h01);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_none("empty_none");
        check_cnt("empty", 4, 3);

        // Terminate then start in one word: start ignored, following data not framed.
        send(START_W, 8'h01);
        send(A, 8'h00);
        send(TS_W, 8'hFC);
        send(B, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_beat("ts_a", A, 8'hFF, 1'b0, 1'b0);
        expect_beat("ts_tail", 64'h0000_0000_0000_7766, 8'h03, 1'b1, 1'b0);
        expect_none("ts_none");
        check_cnt("ts", 5, 3);

        // Start word inside a frame errors it and opens a new one.
        send(START_W, 8'h01);
        send(A, 8'h00);
        send(START_W, 8'h01);
        send(B, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        expect_beat("rs_a", A, 8'hFF, 1'b1, 1'b1);
        expect_beat("rs_b", B, 8'hFF, 1'b1, 1'b0);
        expect_none("rs_none");
        check_cnt("rs", 6, 4);

        // 193 data words overflow a 192-word limit.
        send(START_W, 8'h01);
        for (int i = 1; i <= 193; i++) send(ow(i), 8'h00);
        send(D, 8'h00);
        send(D, 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        for (int i = 1; i <= 192; i++)
            expect_beat($sformatf("ovf%0d", i), ow(i), 8'hFF, i == 192, i == 192);
        expect_none("ovf_none");
        check_cnt("ovf", 6, 5);

        // Exactly 192 words is a good frame.
        send(START_W, 8'h01);
        for (int i = 1; i <= 192; i++) send(ow(i), 8'h00);
        send(TERM0_W, 8'h01);
        idle(3);
        for (int i = 1; i <= 192; i++)
            expect_beat($sformatf("max%0d", i), ow(i), 8'hFF, i == 192, 1'b0);
        expect_none("max_none");
        check_cnt("max", 7, 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_framer.md
# xgmii_rx_framer

Receive framer that sits directly downstream of the XGMII lane-alignment stage and consumes its aligned 64-bit XGMII word stream, in which every start control character is on lane 0. It checks the preamble/SFD, strips framing, and emits each frame as a registered 64-bit beat stream with byte keep, last and error flags. It also keeps frame and error counters. There is no backpressure: the XGMII receive side cannot stall.

## Interface
- `MaxWords`, default 192: maximum data beats per frame; beat 193 onward forces an error end.
- `xgmii_rx_clk` input, 1: sole clock.
- `sys_rst_n` input, 1: reset, asynchronous, active-low.
- `xgmii_rxd` input, 64: aligned receive data, lane k = bits [8k+7:8k].
- `xgmii_rxc` input, 8: aligned control flags, bit k for lane k.
- `rx_data` output, 64: frame data, lane 0 = first byte.
- `rx_keep` output, 8: valid-byte mask, contiguous from bit 0.
- `rx_valid` output, 1: beat valid.
- `rx_last` output, 1: final beat of the frame.
- `rx_err` output, 1: qualifies the last beat; the frame is bad.
- `frame_cnt` output, 32: good frames completed, wraps.
- `err_cnt` output, 32: bad or discarded frames, wraps.

## Operation
- Characters: start = rxc 1 / 0xFB, terminate = rxc 1 / 0xFD, error = rxc 1 / 0xFE.
- A valid start word is start on lane 0, 0x55 with rxc 0 on lanes 1–6, and 0xD5 with rxc 0 on lane 7. This is a single input word.
- States:
  - IDLE: waits for a valid start word, then goes to DATA.
  - DATA: collects data words.
  - DISCARD: waits for a word containing a terminate or start, then goes to IDLE.
- Preamble mismatch in IDLE: the word is ignored, err_cnt +1, stay in IDLE.
- Hold register: each DATA word is loaded into hold. It is emitted when the next input word is classified:
  - Next word has no control bytes: hold is emitted with keep 0xFF, last 0.
  - Next word has terminate at lane k = 0: hold is emitted with keep 0xFF, last 1.
  - Next word has terminate at lane k ≥ 1: hold is emitted as a non-last beat. Lanes 0..k-1 of that word are loaded into hold and emitted next cycle with keep = (1<<k)-1, last 1.
  - Lanes after the terminate are ignored.
- Error ends: hold is emitted with last 1, err 1, err_cnt +1. Causes:
  - Any control byte other than terminate before the terminate lane (including 0xFE).
  - A start lane in DATA.
  - A beat count exceeding MaxWords.
- After an error end:
  - Start-in-DATA: if the word is also a valid start word, go to DATA for a new frame; otherwise go to IDLE.
  - Other causes: go to DISCARD, unless the offending word itself contains a terminate, in which case go to IDLE.
- Partial-lane error: if a control error occurs at lane j ≥ 1 and hold is empty, lanes 0..j-1 are emitted with err.
- Empty frame (terminate on lane 0 of the first word after start): no beat is emitted, err_cnt +1.
- Counters: frame_cnt +1 on the cycle a good last beat is emitted. The beat counter is 9 bits, cleared at start.

## Timing
- Reset values: rx_data 0, rx_keep 0, rx_valid 0, rx_last 0, rx_err 0, both counters 0, state IDLE, hold empty.
- Latency: the input word sampled at edge n has its bytes on rx_* after edge n+2. The rx_* outputs and counters are all registered.
- rx_valid is never high on consecutive frames without rx_last in between. There is at most one beat per cycle.
- Counters update on the same edge as the corresponding rx_last, or on the discard decision.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). The partial frame is lost with no counter change. After release, the block waits for a fresh start word.
- Terminate and start in the same word: the terminate ends the frame; the start is ignored and the next frame needs its own start word.

## Structure
- Shared package `xgmii_pkg`: character constants (0x07, 0xFB, 0xFD, 0xFE, 0x55, 0xD5) and the state enum.
- Sub-module `xgmii_lane_decode`: combinational per-word decode giving terminate-lane index, first-error-lane index, control-present flag and start-word-valid flag.
- The top level holds the FSM, hold register, beat counter and counters.

## Test plan
- Start word, then words A, B, then FD on lane 0 → two beats A, B, keep 0xFF, last on B, frame_cnt 1.
- Start, A, then FD on lane 3 with bytes 11 22 33 → beats A (keep 0xFF) and 0x332211 (keep 0x07, last 1).
- Start with lane 7 = 0xD4 → no beats, err_cnt 1, next valid frame received normally.
- Start, A, then 0xFE on lane 0 → A with last 1, err 1. Input stays in DISCARD until FD; err_cnt 1.
- Frame of 193 data words with MaxWords 192 → beat 192 carries last 1, err 1; remaining words discarded until FD.
- Reset pulsed during beat 2 of a 5-word frame → outputs zero immediately, counters unchanged, next frame clean.
